// File: rtl/cpu_pkg.sv
// Shared CPU datapath definitions: divider FSM states and defaults.
// Used by iter_div (optional signed support via DIV_SIGNED_EN).
package cpu_pkg;

  localparam int DIV_WIDTH      = 16;
  localparam bit BYPASS_TRIVIAL = 1'b1;

  typedef enum logic [2:0] {
    D_IDLE = 3'd0,
    D_PREP = 3'd1,
    D_ITER = 3'd2,
    D_FIX  = 3'd3,
    D_DONE = 3'd4
  } t_div_state;

endpackage

// File: rtl/div_step.sv
// One restoring division step: shift in a dividend bit,
// trial-subtract the divisor, keep the difference if non-negative.
module div_step #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH:0]   rem_i,
  input  logic [WIDTH-1:0] dvs_i,
  input  logic             bit_i,
  output logic [WIDTH:0]   rem_o,
  output logic             q_o
);

  logic [WIDTH:0] sh;
  logic [WIDTH:0] diff;

  // Trial subtraction; a set top bit always exceeds the divisor
  always_comb begin
    sh    = {rem_i[WIDTH-1:0], bit_i};
    diff  = sh - {1'b0, dvs_i};
    q_o   = rem_i[WIDTH] | (sh >= {1'b0, dvs_i});
    rem_o = q_o ? diff : sh;
  end

endmodule

// File: rtl/iter_div.sv
// Iterative restoring divider, one quotient bit per cycle.
// Define DIV_SIGNED_EN to add signed_op and two's-complement support.
module iter_div #(
  parameter int WIDTH          = cpu_pkg::DIV_WIDTH,
  parameter bit BYPASS_TRIVIAL = cpu_pkg::BYPASS_TRIVIAL
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
`ifdef DIV_SIGNED_EN
  input  logic             signed_op,
`endif
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  import cpu_pkg::*;

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);
  localparam logic [WIDTH-1:0] MIN = {1'b1, {(WIDTH-1){1'b0}}};

  t_div_state state_q, state_d;
  logic rdy_q, rdy_d;
  logic [WIDTH-1:0] dvd_q, dvd_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [WIDTH-1:0] mag_q, mag_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH:0] rem_q, rem_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic dbz_q, dbz_d;
  logic qneg_q, qneg_d;
  logic rneg_q, rneg_d;
  logic is_sgn, ovf;
  logic dvd_neg, dvs_neg;
  logic [WIDTH-1:0] dvd_mag, dvs_mag;
  logic [WIDTH:0] step_rem;
  logic step_q;

`ifdef DIV_SIGNED_EN
  logic sgn_q, sgn_d;
`endif

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem_i (rem_q),
    .dvs_i (mag_q),
    .bit_i (quo_q[WIDTH-1]),
    .rem_o (step_rem),
    .q_o   (step_q)
  );

  // Operand signs, magnitudes and the MIN / -1 overflow case
  always_comb begin
`ifdef DIV_SIGNED_EN
    is_sgn = sgn_q;
    ovf    = sgn_q && (dvd_q == MIN) && (&dvs_q);
`else
    is_sgn = 1'b0;
    ovf    = 1'b0;
`endif
    dvd_neg = is_sgn & dvd_q[WIDTH-1];
    dvs_neg = is_sgn & dvs_q[WIDTH-1];
    dvd_mag = dvd_neg ? -dvd_q : dvd_q;
    dvs_mag = dvs_neg ? -dvs_q : dvs_q;
  end

  // Next-state and datapath sequencing
  always_comb begin
    state_d = state_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    mag_d   = mag_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    cnt_d   = cnt_q;
    dbz_d   = dbz_q;
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
`ifdef DIV_SIGNED_EN
    sgn_d   = sgn_q;
`endif
    unique case (state_q)
      D_IDLE: begin
        if (start_valid && rdy_q) begin
          dvd_d   = dividend;
          dvs_d   = divisor;
`ifdef DIV_SIGNED_EN
          sgn_d   = signed_op;
`endif
          state_d = D_PREP;
        end
      end
      D_PREP: begin
        qneg_d  = dvd_neg ^ dvs_neg;
        rneg_d  = dvd_neg;
        mag_d   = dvs_mag;
        dbz_d   = 1'b0;
        rem_d   = '0;
        state_d = D_DONE;
        if (dvs_q == '0) begin
          quo_d = '1;
          rem_d = {1'b0, dvd_q};
          dbz_d = 1'b1;
        end else if (ovf) begin
          quo_d = MIN;
        end else if (BYPASS_TRIVIAL && dvs_mag == ONE) begin
          quo_d = dvs_neg ? -dvd_q : dvd_q;
        end else if (BYPASS_TRIVIAL && dvd_mag < dvs_mag) begin
          quo_d = '0;
          rem_d = {1'b0, dvd_q};
        end else begin
          quo_d   = dvd_mag;
          cnt_d   = '0;
          state_d = D_ITER;
        end
      end
      D_ITER: begin
        rem_d = step_rem;
        quo_d = {quo_q[WIDTH-2:0], step_q};
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST) state_d = D_FIX;
      end
      D_FIX: begin
        if (qneg_q) quo_d = -quo_q;
        if (rneg_q) rem_d = {1'b0, -rem_q[WIDTH-1:0]};
        state_d = D_DONE;
      end
      D_DONE: begin
        if (res_ready) state_d = D_IDLE;
      end
      default: state_d = D_IDLE;
    endcase
    rdy_d = (state_d == D_IDLE);
  end

  // State registers; reset discards any in-flight result
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= D_IDLE;
      rdy_q   <= 1'b0;
      dvd_q   <= '0;
      dvs_q   <= '0;
      mag_q   <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
      cnt_q   <= '0;
      dbz_q   <= 1'b0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
`ifdef DIV_SIGNED_EN
      sgn_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      rdy_q   <= rdy_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      mag_q   <= mag_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      cnt_q   <= cnt_d;
      dbz_q   <= dbz_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
`ifdef DIV_SIGNED_EN
      sgn_q   <= sgn_d;
`endif
    end
  end

  assign start_ready = rdy_q;
  assign res_valid   = (state_q == D_DONE);
  assign quotient    = quo_q;
  assign remainder   = rem_q[WIDTH-1:0];
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_iter_div.sv
// Directed bench for iter_div: bypass and non-bypass builds side by side.
// Signed vectors run only when DIV_SIGNED_EN is defined.
module tb_iter_div;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [15:0] dividend = '0;
  logic [15:0] divisor = '0;
  logic signed_op = 1'b0;

  logic sv0 = 1'b0, rr0 = 1'b0;
  logic rdy0, vld0, z0;
  logic [15:0] q0, r0;

  logic sv1 = 1'b0, rr1 = 1'b0;
  logic rdy1, vld1, z1;
  logic [15:0] q1, r1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  iter_div #(.WIDTH(16), .BYPASS_TRIVIAL(1'b1)) u_dut (
    .clk         (clk),
    .rst         (rst),
    .start_valid (sv0),
    .start_ready (rdy0),
    .dividend    (dividend),
    .divisor     (divisor),
`ifdef DIV_SIGNED_EN
    .signed_op   (signed_op),
`endif
    .res_valid   (vld0),
    .res_ready   (rr0),
    .quotient    (q0),
    .remainder   (r0),
    .div_by_zero (z0)
  );

  iter_div #(.WIDTH(16), .BYPASS_TRIVIAL(1'b0)) u_nb (
    .clk         (clk),
    .rst         (rst),
    .start_valid (sv1),
    .start_ready (rdy1),
    .dividend    (dividend),
    .divisor     (divisor),
`ifdef DIV_SIGNED_EN
    .signed_op   (signed_op),
`endif
    .res_valid   (vld1),
    .res_ready   (rr1),
    .quotient    (q1),
    .remainder   (r1),
    .div_by_zero (z1)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic run(input bit nb, input logic [15:0] a,
                     input logic [15:0] b, input bit so,
                     input logic [15:0] eq, input logic [15:0] er,
                     input logic ez, input int ecyc, input string tag);
    int n;
    n = 0;
    while (!(nb ? rdy1 : rdy0) && n < 50) begin
      @(posedge clk); #1; n++;
    end
    dividend = a;
    divisor = b;
    signed_op = so;
    if (nb) sv1 = 1'b1; else sv0 = 1'b1;
    @(posedge clk); #1;
    sv0 = 1'b0; sv1 = 1'b0; signed_op = 1'b0;
    n = 1;
    while (!(nb ? vld1 : vld0) && n < 60) begin
      @(posedge clk); #1; n++;
    end
    chk({tag, ".cyc"}, n, ecyc);
    chk({tag, ".q"}, nb ? q1 : q0, eq);
    chk({tag, ".r"}, nb ? r1 : r0, er);
    chk({tag, ".z"}, nb ? z1 : z0, ez);
    if (nb) rr1 = 1'b1; else rr0 = 1'b1;
    @(posedge clk); #1;
    rr0 = 1'b0; rr1 = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    int n;
    #2;
    chk("rst.rdy", rdy0, 1'b0);
    chk("rst.vld", vld0, 1'b0);
    chk("rst.q", q0, 16'h0);
    chk("rst.r", r0, 16'h0);
    chk("rst.z", z0, 1'b0);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("rel.rdy", rdy0, 1'b1);

    run(1'b0, 16'd100, 16'd7, 1'b0, 16'd14, 16'd2, 1'b0, 19, "u100_7");
    run(1'b0, 16'd5, 16'd0, 1'b0, 16'hFFFF, 16'd5, 1'b1, 2, "dz5_0");
    run(1'b0, 16'd3, 16'd10, 1'b0, 16'd0, 16'd3, 1'b0, 2, "byp3_10");
    run(1'b1, 16'd3, 16'd10, 1'b0, 16'd0, 16'd3, 1'b0, 19, "nb3_10");
    run(1'b0, 16'd7, 16'd1, 1'b0, 16'd7, 16'd0, 1'b0, 2, "byp7_1");
    run(1'b0, 16'hFFFF, 16'd255, 1'b0, 16'd257, 16'd0, 1'b0, 19, "max_255");
    run(1'b1, 16'd9, 16'd0, 1'b0, 16'hFFFF, 16'd9, 1'b1, 2, "nbdz9_0");
`ifdef DIV_SIGNED_EN
    run(1'b0, 16'hFFF9, 16'd2, 1'b1, 16'hFFFD, 16'hFFFF, 1'b0, 19, "s_m7_2");
    run(1'b0, 16'h8000, 16'hFFFF, 1'b1, 16'h8000, 16'h0, 1'b0, 2, "s_ovf");
    run(1'b1, 16'h8000, 16'hFFFF, 1'b1, 16'h8000, 16'h0, 1'b0, 2, "nbs_ovf");
    run(1'b0, 16'd7, 16'hFFFE, 1'b1, 16'hFFFD, 16'd1, 1'b0, 19, "s_7_m2");
`endif

    // Hold result with res_ready low for five cycles
    n = 0;
    while (!rdy0 && n < 50) begin @(posedge clk); #1; n++; end
    dividend = 16'd1000;
    divisor = 16'd3;
    sv0 = 1'b1;
    @(posedge clk); #1;
    sv0 = 1'b0;
    n = 1;
    while (!vld0 && n < 60) begin @(posedge clk); #1; n++; end
    chk("hold.cyc", n, 19);
    for (int i = 0; i < 5; i++) begin
      chk("hold.q", q0, 16'd333);
      chk("hold.r", r0, 16'd1);
      chk("hold.vld", vld0, 1'b1);
      chk("hold.rdy", rdy0, 1'b0);
      @(posedge clk); #1;
    end
    dividend = 16'd9;
    divisor = 16'd2;
    rr0 = 1'b1;
    sv0 = 1'b1;
    @(posedge clk); #1;
    rr0 = 1'b0;
    chk("post.rdy", rdy0, 1'b1);
    chk("post.vld", vld0, 1'b0);
    chk("post.q", q0, 16'd333);
    sv0 = 1'b0;

    // Reset in the middle of an iteration
    dividend = 16'd1000;
    divisor = 16'd3;
    sv0 = 1'b1;
    @(posedge clk); #1;
    sv0 = 1'b0;
    n = 1;
    while (n < 8) begin @(posedge clk); #1; n++; end
    rst = 1'b1;
    #1;
    chk("mrst.q", q0, 16'h0);
    chk("mrst.r", r0, 16'h0);
    chk("mrst.z", z0, 1'b0);
    chk("mrst.vld", vld0, 1'b0);
    chk("mrst.rdy", rdy0, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    run(1'b0, 16'd50, 16'd5, 1'b0, 16'd10, 16'd0, 1'b0, 19, "r50_5");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
